// File: rtl/tt_check_pkg.sv
// Shared types and constants for exhaustive truth-table checkers.
// Default expected table is the abacbd cell, f = ab | ac | bd.
package tt_check_pkg;

  localparam int TT_W  = 16;
  localparam int IDX_W = 4;

  localparam logic [TT_W-1:0] ABACBD_TT = 16'hFCA0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

endpackage

// File: rtl/settle_timer.sv
// Load/count/expire timer for per-vector settle delays.
// Expires while counting in the cycle the count reaches limit-1.
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [7:0] i_limit,
  output logic       o_expire
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_load) begin
      r_cnt <= 8'd0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expire = i_en && (r_cnt == (i_limit - 8'd1));

endmodule

// File: rtl/tt_exhaustive_checker.sv
// Drives all 16 vectors into a 4-input cell, captures its truth table
// and compares it against an expected table.
module tt_exhaustive_checker
  import tt_check_pkg::*;
#(
  parameter int              SETTLE   = 4,
  parameter logic [TT_W-1:0] EXPECTED = ABACBD_TT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [TT_W-1:0]  captured,
  output logic [4:0]       mismatch_cnt,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             first_fail_vld
);

  localparam logic [7:0] LIM = 8'(SETTLE);

  state_e            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [3:0]        r_drv;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [TT_W-1:0]   r_cap;
  logic [4:0]        r_mis;
  logic [IDX_W-1:0]  r_ffi;
  logic              r_ffv;

  logic              w_accept;
  logic              w_expire;
  logic              w_bad;
  logic [4:0]        w_mis_nxt;

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_bad     = f ^ EXPECTED[r_idx];
  assign w_mis_nxt = r_mis + {4'd0, w_bad};

  settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_accept || (r_state == ST_SAMPLE)),
    .i_en     (r_state == ST_APPLY),
    .i_limit  (LIM),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_drv   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_cap   <= '0;
      r_mis   <= '0;
      r_ffi   <= '0;
      r_ffv   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_drv  <= '0;
          if (start) begin
            r_state <= ST_APPLY;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_pass  <= 1'b0;
            r_cap   <= '0;
            r_mis   <= '0;
            r_ffi   <= '0;
            r_ffv   <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (w_expire) r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          r_cap[r_idx] <= f;
          r_mis        <= w_mis_nxt;
          if (w_bad && !r_ffv) begin
            r_ffi <= r_idx;
            r_ffv <= 1'b1;
          end
          // Pass must reflect the final sample, so use the next count.
          if (r_idx == 4'd15) begin
            r_state <= ST_REPORT;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_mis_nxt == 5'd0);
            r_drv   <= '0;
          end else begin
            r_state <= ST_APPLY;
            r_idx   <= r_idx + 4'd1;
            r_drv   <= r_idx + 4'd1;
          end
        end
        ST_REPORT: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign {a, b, c, d}   = r_drv;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign captured       = r_cap;
  assign mismatch_cnt   = r_mis;
  assign first_fail_idx = r_ffi;
  assign first_fail_vld = r_ffv;

endmodule

// File: tb/tb_tt_exhaustive_checker.sv
// Directed bench: good, stuck-at-0 and inverted cells, SETTLE=1 sweep,
// mid-run reset, ignored start and back-to-back runs.
module tb_tt_exhaustive_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start0, start1;
  int   mode;
  int   checks = 0;
  int   failures = 0;

  logic a0, b0, c0, d0, f0, busy0, done0, pass0, ffv0;
  logic [15:0] cap0;
  logic [4:0]  mis0;
  logic [3:0]  ffi0;
  logic [3:0]  v0;

  logic a1, b1, c1, d1, f1, busy1, done1, pass1, ffv1;
  logic [15:0] cap1;
  logic [4:0]  mis1;
  logic [3:0]  ffi1;
  logic [3:0]  v1;

  assign v0 = {a0, b0, c0, d0};
  assign v1 = {a1, b1, c1, d1};

  logic good0;
  assign good0 = (a0 & b0) | (a0 & c0) | (b0 & d0);
  always_comb begin
    f0 = good0;
    if (mode == 1) f0 = 1'b0;
    else if (mode == 2) f0 = ~good0;
  end
  assign f1 = (a1 & b1) | (a1 & c1) | (b1 & d1);

  tt_exhaustive_checker #(.SETTLE(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .a(a0), .b(b0), .c(c0), .d(d0), .f(f0),
    .busy(busy0), .done(done0), .pass(pass0),
    .captured(cap0), .mismatch_cnt(mis0),
    .first_fail_idx(ffi0), .first_fail_vld(ffv0)
  );

  tt_exhaustive_checker #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1), .f(f1),
    .busy(busy1), .done(done1), .pass(pass1),
    .captured(cap1), .mismatch_cnt(mis1),
    .first_fail_idx(ffi1), .first_fail_vld(ffv1)
  );

  // Leaves the bench #1 after edge T0+1; n = 1 there.
  task automatic pulse0(output int n);
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    n = 1;
  endtask

  task automatic wait_done0(inout int n);
    while (!done0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({v0, busy0, done0, pass0, ffv0} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctl got=%h exp=00", {v0, busy0, done0, pass0, ffv0});
    end
    checks++;
    if ({cap0, mis0, ffi0} !== 25'd0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {cap0, mis0, ffi0});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_correct();
    int n;
    mode = 0;
    pulse0(n);
    checks++;
    if ({busy0, v0} !== 5'b1_0000) begin
      failures++;
      $display("FAIL good_start got=%b exp=10000", {busy0, v0});
    end
    wait_done0(n);
    checks++;
    if (n !== 81) begin failures++; $display("FAIL good_latency got=%0d exp=81", n); end
    checks++;
    if (cap0 !== 16'hFCA0) begin failures++; $display("FAIL good_cap got=%h exp=fca0", cap0); end
    checks++;
    if ({pass0, mis0, ffv0, busy0} !== {1'b1, 5'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL good_status got=%b%h%b%b exp=10000000", pass0, mis0, ffv0, busy0);
    end
    @(posedge clk); #1;
    checks++;
    if ({done0, pass0} !== 2'b01) begin
      failures++;
      $display("FAIL good_hold got=%b exp=01", {done0, pass0});
    end
  endtask

  task automatic test_zero();
    int n;
    mode = 1;
    pulse0(n);
    wait_done0(n);
    checks++;
    if (n !== 81) begin failures++; $display("FAIL zero_latency got=%0d exp=81", n); end
    checks++;
    if (cap0 !== 16'h0000) begin failures++; $display("FAIL zero_cap got=%h exp=0000", cap0); end
    checks++;
    if ({pass0, mis0, ffi0, ffv0} !== {1'b0, 5'd8, 4'd5, 1'b1}) begin
      failures++;
      $display("FAIL zero_status got pass=%b mis=%0d ffi=%0d ffv=%b exp 0/8/5/1",
               pass0, mis0, ffi0, ffv0);
    end
  endtask

  task automatic test_inverted();
    int n;
    mode = 2;
    pulse0(n);
    wait_done0(n);
    checks++;
    if (cap0 !== 16'h035F) begin failures++; $display("FAIL inv_cap got=%h exp=035f", cap0); end
    checks++;
    if ({pass0, mis0, ffi0, ffv0} !== {1'b0, 5'd16, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL inv_status got pass=%b mis=%0d ffi=%0d ffv=%b exp 0/16/0/1",
               pass0, mis0, ffi0, ffv0);
    end
  endtask

  task automatic test_settle1();
    logic [3:0] ev;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k <= 32) begin
        ev = 4'((k - 1) / 2);
        checks++;
        if ({busy1, v1} !== {1'b1, ev}) begin
          failures++;
          $display("FAIL s1_vec cyc=%0d got=%b_%h exp=1_%h", k, busy1, v1, ev);
        end
      end
      checks++;
      if (done1 !== (k == 33)) begin
        failures++;
        $display("FAIL s1_done cyc=%0d got=%b exp=%b", k, done1, (k == 33));
      end
    end
    checks++;
    if ({cap1, pass1, mis1} !== {16'hFCA0, 1'b1, 5'd0}) begin
      failures++;
      $display("FAIL s1_result got=%h/%b/%0d exp=fca0/1/0", cap1, pass1, mis1);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    int t;
    mode = 0;
    pulse0(n);
    t = 0;
    while (v0 !== 4'd7 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (v0 !== 4'd7) begin failures++; $display("FAIL mid_reach got=%h exp=7", v0); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({v0, busy0, done0, pass0, ffv0, cap0, mis0, ffi0} !== 33'd0) begin
      failures++;
      $display("FAIL mid_async got v=%h busy=%b cap=%h mis=%0d exp all 0", v0, busy0, cap0, mis0);
    end
    @(negedge clk) rst_n = 1'b1;
    pulse0(n);
    checks++;
    if ({busy0, v0, cap0, mis0} !== {1'b1, 4'd0, 16'd0, 5'd0}) begin
      failures++;
      $display("FAIL mid_restart got busy=%b v=%h cap=%h exp 1/0/0", busy0, v0, cap0);
    end
    wait_done0(n);
    checks++;
    if ({n == 81, cap0, pass0, mis0} !== {1'b1, 16'hFCA0, 1'b1, 5'd0}) begin
      failures++;
      $display("FAIL mid_rerun got n=%0d cap=%h pass=%b mis=%0d exp 81/fca0/1/0", n, cap0, pass0, mis0);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    mode = 0;
    pulse0(n);
    repeat (8) begin @(posedge clk); #1; n++; end
    start0 = 1'b1;
    @(posedge clk); #1; n++;
    start0 = 1'b0;
    wait_done0(n);
    checks++;
    if (n !== 81) begin failures++; $display("FAIL ign_latency got=%0d exp=81", n); end
  endtask

  task automatic test_back_to_back();
    int n;
    mode = 0;
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1;
    n = 1;
    wait_done0(n);
    checks++;
    if ({n == 81, pass0} !== 2'b11) begin
      failures++;
      $display("FAIL b2b_first got n=%0d pass=%b exp 81/1", n, pass0);
    end
    @(posedge clk); #1; n++;
    checks++;
    if ({busy0, pass0} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_idle got busy=%b pass=%b exp 0/1", busy0, pass0);
    end
    @(posedge clk); #1; n++;
    start0 = 1'b0;
    checks++;
    if ({busy0, pass0, cap0} !== {1'b1, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL b2b_accept got busy=%b pass=%b cap=%h exp 1/0/0000", busy0, pass0, cap0);
    end
    wait_done0(n);
    checks++;
    if ({n == 163, pass0, cap0} !== {1'b1, 1'b1, 16'hFCA0}) begin
      failures++;
      $display("FAIL b2b_second got n=%0d pass=%b cap=%h exp 163/1/fca0", n, pass0, cap0);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    mode   = 0;
    test_reset();
    test_correct();
    test_zero();
    test_inverted();
    test_settle1();
    test_reset_midrun();
    test_start_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_exhaustive_checker.md
# tt_exhaustive_checker

Self-checking hardware response analyser for 4-input combinational cells such as the `abacbd` gate (f = ab + ac + bd).
- On `start`, drives all 16 input vectors in ascending order.
- Waits a programmable settle time per vector, then samples the cell output.
- Assembles a 16-bit captured truth table and compares it against an expected table.
- Reports pass/fail, mismatch count and first failing vector.
- Sits beside the cell under test in silicon/FPGA bring-up, replacing the simulation-only stimulus fixture.

## Interface
Parameters:
- `SETTLE`, default 4: cycles each vector is held before sampling; legal range 1..255.
- `EXPECTED`, default 16'hFCA0: expected truth table; bit i = f for {a,b,c,d} = i, with a as MSB.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level-sampled; accepted only in IDLE.
- `a`, `b`, `c`, `d`  out  1 each  registered drive to the cell under test.
- `f`  in  1  cell output; combinational from a..d, same clock domain, no synchroniser.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse when the result is valid.
- `pass`  out  1  captured == EXPECTED; held until the next accepted `start`.
- `captured`  out  16  captured truth table.
- `mismatch_cnt`  out  5  popcount(captured ^ EXPECTED), range 0..16.
- `first_fail_idx`  out  4  lowest failing vector index.
- `first_fail_vld`  out  1  at least one mismatch.

## Operation
- FSM states: IDLE, APPLY, SAMPLE, REPORT.
- IDLE:
  - a..d = 0, `busy` = 0.
  - `start`=1 → APPLY with idx = 0, settle counter = 0.
  - Clears `captured`, `mismatch_cnt`, `first_fail_*` and `pass`.
- APPLY:
  - {a,b,c,d} = idx, registered.
  - Counter increments each cycle; when counter == SETTLE-1 → SAMPLE.
- SAMPLE (one cycle):
  - `captured[idx]` <= f.
  - If f != EXPECTED[idx]: `mismatch_cnt` increments; if `first_fail_vld` is 0, set `first_fail_idx` = idx and `first_fail_vld` = 1.
  - idx == 15 → REPORT; else idx+1, counter = 0 → APPLY.
- REPORT (one cycle):
  - `done` = 1, `pass` = (`mismatch_cnt` == 0), `busy` = 0 → IDLE.
- `start` during APPLY/SAMPLE/REPORT is ignored (no restart, no queueing).
- `start` held high continuously re-runs back-to-back; each run clears results on acceptance.
- idx is 4-bit and never wraps past 15 within a run.
- `mismatch_cnt` is 5-bit, so 16 mismatches saturate nowhere.
- Reset (any state, including mid-run): immediately IDLE; all outputs 0; partial results discarded.

## Timing
- Reset values: a..d = 0, `busy` = 0, `done` = 0, `pass` = 0, `captured` = 0, `mismatch_cnt` = 0, `first_fail_idx` = 0, `first_fail_vld` = 0.
- `start` sampled at edge T0 → `busy` = 1 and {a,b,c,d} = 0 from T0+1.
- Each vector is driven for SETTLE cycles of APPLY plus 1 SAMPLE cycle. The drive is stable during SAMPLE; f is captured at the edge ending SAMPLE.
- Vector i is driven from T0+1+i·(SETTLE+1).
- `done` is high in cycle T0+1+16·(SETTLE+1). With SETTLE=4, `done` is at T0+81.
- `pass` and counters are valid in the `done` cycle and held afterwards.
- Earliest re-accepted `start`: the cycle after `done`.

## Structure
- Package `tt_check_pkg`:
  - state enum {IDLE, APPLY, SAMPLE, REPORT};
  - `TT_W` = 16, `IDX_W` = 4;
  - default constant `ABACBD_TT` = 16'hFCA0.
- One natural sub-module: `settle_timer` (load/count/expire, width 8), reusable for other cell checkers.
- Everything else lives in the top FSM.

## Test plan
- Correct cell (f = ab|ac|bd), SETTLE=4, pulse `start` → `done` at T0+81, `captured` = 16'hFCA0, `pass` = 1, `mismatch_cnt` = 0, `first_fail_vld` = 0.
- f tied to 0 → `captured` = 0, `pass` = 0, `mismatch_cnt` = 8, `first_fail_idx` = 5, `first_fail_vld` = 1.
- Cell inverted (CMOS-style ~f) → `captured` = 16'h035F, `mismatch_cnt` = 16, `first_fail_idx` = 0.
- SETTLE=1 → each vector driven exactly 2 cycles (APPLY + SAMPLE); `done` at T0+33; a..d sequence is 0..15 in ascending order, checked cycle by cycle.
- Assert `rst_n`=0 at vector 7 mid-run → all outputs 0 asynchronously; `start` after release restarts from vector 0 with cleared counters.
- `start` pulsed again during APPLY → ignored, `done` timing unchanged; `start` held high → second run begins the cycle after `done`, with `pass` cleared on acceptance.
